// File: rtl/mux21_pkg.sv
// Shared types and constants for the 2:1 round-robin mux arbiter and its datapath.
package mux21_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_MAX_BEATS = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux21_dp.sv
// WIDTH+1-bit 2:1 mux carrying data and last; sel picks in0 (SEL_A) or in1 (SEL_B).
module mux21_dp
  import mux21_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  logic [WIDTH:0] w_a;
  logic [WIDTH:0] w_b;
  logic [WIDTH:0] w_y;

  assign w_a = {in0_last, in0_data};
  assign w_b = {in1_last, in1_data};

  always_comb begin
    w_y = w_a;
    if (sel == SEL_B) begin
      w_y = w_b;
    end else begin
      w_y = w_a;
    end
  end

  assign out_data = w_y[WIDTH-1:0];
  assign out_last = w_y[WIDTH];

endmodule

// File: rtl/mux21_rr_arb.sv
// Round-robin burst arbiter sharing one valid/ready channel between in0 and in1.
// Optional forced handover after MAX_BEATS beats when MUX21_ARB_TIMEOUT_EN is defined.
module mux21_rr_arb
  import mux21_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BEATS = DEFAULT_MAX_BEATS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
`ifdef MUX21_ARB_TIMEOUT_EN
 ,output logic             preempt
`endif
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_prio;
  logic       w_prio_nxt;
  logic       r_sel;
  logic       w_sel_nxt;
  logic       w_fire;
  logic       w_cap;
  logic       w_preempt_evt;

  assign w_fire = out_valid & out_ready;

  // Burst-limit tracking: cap fires on the beat that brings the count to MAX_BEATS.
`ifdef MUX21_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_grant_new;
  logic             r_preempt;

  assign w_grant_new = (w_state_nxt != IDLE) && (w_state_nxt != r_state);
  assign w_cap       = w_fire && (r_cnt == CNT_W'(MAX_BEATS - 1));

  // Beat counter: cleared on every new grant, saturates at MAX_BEATS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_grant_new) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_fire && (r_cnt != CNT_W'(MAX_BEATS))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // One-cycle handover pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= w_preempt_evt;
    end
  end

  assign preempt = r_preempt;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (MAX_BEATS >= 1);
  assign w_cap        = 1'b0;
`endif

  // Next state, round-robin pointer and handover event.
  always_comb begin
    w_state_nxt   = r_state;
    w_prio_nxt    = r_prio;
    w_preempt_evt = 1'b0;
    case (r_state)
      IDLE: begin
        if (in0_valid && (!in1_valid || (r_prio == SEL_A))) begin
          w_state_nxt = GNT0;
        end else if (in1_valid) begin
          w_state_nxt = GNT1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GNT0: begin
        if (w_fire && in0_last) begin
          w_prio_nxt  = SEL_B;
          w_state_nxt = in1_valid ? GNT1 : IDLE;
        end else if (w_cap && in1_valid) begin
          w_prio_nxt    = SEL_B;
          w_state_nxt   = GNT1;
          w_preempt_evt = 1'b1;
        end else begin
          w_state_nxt = GNT0;
        end
      end
      GNT1: begin
        if (w_fire && in1_last) begin
          w_prio_nxt  = SEL_A;
          w_state_nxt = in0_valid ? GNT0 : IDLE;
        end else if (w_cap && in0_valid) begin
          w_prio_nxt    = SEL_A;
          w_state_nxt   = GNT0;
          w_preempt_evt = 1'b1;
        end else begin
          w_state_nxt = GNT1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Select tracks the grant being entered; IDLE keeps the last value.
  always_comb begin
    w_sel_nxt = r_sel;
    case (w_state_nxt)
      GNT0:    w_sel_nxt = SEL_A;
      GNT1:    w_sel_nxt = SEL_B;
      default: w_sel_nxt = r_sel;
    endcase
  end

  // State, priority and select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= SEL_A;
      r_sel   <= SEL_A;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Handshake steering: only the granted side sees out_ready.
  always_comb begin
    out_valid = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (r_state)
      GNT0: begin
        out_valid = in0_valid;
        in0_ready = out_ready;
      end
      GNT1: begin
        out_valid = in1_valid;
        in1_ready = out_ready;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign sel  = r_sel;
  assign busy = (r_state != IDLE);

  mux21_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .sel      (r_sel),
    .in0_data (in0_data),
    .in0_last (in0_last),
    .in1_data (in1_data),
    .in1_last (in1_last),
    .out_data (out_data),
    .out_last (out_last)
  );

endmodule

// File: tb/tb_mux21_rr_arb.sv
// Table-driven bench for mux21_rr_arb; the burst-limit sequence runs when MUX21_ARB_TIMEOUT_EN is defined.
module tb_mux21_rr_arb;
  import mux21_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in0_last, in0_ready;
  logic [7:0] in0_data;
  logic       in1_valid, in1_last, in1_ready;
  logic [7:0] in1_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       sel, busy;
`ifdef MUX21_ARB_TIMEOUT_EN
  logic       preempt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux21_rr_arb #(
    .WIDTH(8),
    .MAX_BEATS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
`ifdef MUX21_ARB_TIMEOUT_EN
   ,.preempt(preempt)
`endif
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       rdy;
    logic       ev;
    logic       cd;
    logic [7:0] ed;
    logic       el;
    logic       er0;
    logic       er1;
    logic       esel;
    logic       ebusy;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  function automatic vec_t mk(input int r, input int v0, input int d0, input int l0,
                              input int v1, input int d1, input int l1, input int rdy,
                              input int ev, input int cd, input int ed, input int el,
                              input int er0, input int er1, input int es, input int eb);
    vec_t v;
    v.rst = r[0];   v.v0 = v0[0];  v.d0 = 8'(d0);  v.l0 = l0[0];
    v.v1 = v1[0];   v.d1 = 8'(d1); v.l1 = l1[0];   v.rdy = rdy[0];
    v.ev = ev[0];   v.cd = cd[0];  v.ed = 8'(ed);  v.el = el[0];
    v.er0 = er0[0]; v.er1 = er1[0]; v.esel = es[0]; v.ebusy = eb[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    in0_valid = 1'b0; in0_data = 8'h00; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = 8'h00; in1_last = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    // columns: rst, v0,d0,l0, v1,d1,l1, rdy | ev,chk_data,data,last, rdy0,rdy1, sel,busy
    // single requester in0, then prio=1 shown by in1 winning a tie
    tbl[0]  = mk(0, 1,'h11,0, 0,'h00,0, 1,  0,0,'h00,0, 0,0, 0,0);
    tbl[1]  = mk(0, 1,'h11,0, 0,'h00,0, 1,  1,1,'h11,0, 1,0, 0,1);
    tbl[2]  = mk(0, 1,'h22,0, 0,'h00,0, 1,  1,1,'h22,0, 1,0, 0,1);
    tbl[3]  = mk(0, 1,'h33,1, 0,'h00,0, 1,  1,1,'h33,1, 1,0, 0,1);
    tbl[4]  = mk(0, 0,'h00,0, 0,'h00,0, 1,  0,0,'h00,0, 0,0, 0,0);
    tbl[5]  = mk(0, 1,'h55,1, 1,'h66,1, 1,  0,0,'h00,0, 0,0, 0,0);
    tbl[6]  = mk(0, 1,'h55,1, 1,'h66,1, 1,  1,1,'h66,1, 0,1, 1,1);
    tbl[7]  = mk(0, 1,'h55,1, 0,'h00,0, 1,  1,1,'h55,1, 1,0, 0,1);
    tbl[8]  = mk(0, 0,'h00,0, 0,'h00,0, 1,  0,0,'h00,0, 0,0, 0,0);
    // simultaneous 2-beat bursts out of reset, no bubble at handover
    tbl[9]  = mk(1, 1,'h01,0, 1,'hA0,0, 1,  0,0,'h00,0, 0,0, 0,0);
    tbl[10] = mk(0, 1,'h01,0, 1,'hA0,0, 1,  0,0,'h00,0, 0,0, 0,0);
    tbl[11] = mk(0, 1,'h01,0, 1,'hA0,0, 1,  1,1,'h01,0, 1,0, 0,1);
    tbl[12] = mk(0, 1,'h02,1, 1,'hA0,0, 1,  1,1,'h02,1, 1,0, 0,1);
    tbl[13] = mk(0, 0,'h00,0, 1,'hA0,0, 1,  1,1,'hA0,0, 0,1, 1,1);
    tbl[14] = mk(0, 0,'h00,0, 1,'hA1,1, 1,  1,1,'hA1,1, 0,1, 1,1);
    tbl[15] = mk(0, 0,'h00,0, 0,'h00,0, 1,  0,0,'h00,0, 0,0, 1,0);
    tbl[16] = mk(0, 1,'h03,1, 1,'hC0,0, 1,  0,0,'h00,0, 0,0, 1,0);
    tbl[17] = mk(0, 1,'h03,1, 1,'hC0,0, 1,  1,1,'h03,1, 1,0, 0,1);
    // backpressure in GNT1: out_ready 1,0,0,1
    tbl[18] = mk(0, 0,'h00,0, 1,'hC0,0, 1,  1,1,'hC0,0, 0,1, 1,1);
    tbl[19] = mk(0, 0,'h00,0, 1,'hC1,0, 0,  1,1,'hC1,0, 0,0, 1,1);
    tbl[20] = mk(0, 0,'h00,0, 1,'hC1,0, 0,  1,1,'hC1,0, 0,0, 1,1);
    tbl[21] = mk(0, 0,'h00,0, 1,'hC1,0, 1,  1,1,'hC1,0, 0,1, 1,1);
    tbl[22] = mk(0, 0,'h00,0, 1,'hC2,1, 1,  1,1,'hC2,1, 0,1, 1,1);
    // reset mid-burst with prio=1, then a tie must go to in0
    tbl[23] = mk(0, 1,'hF0,1, 0,'h00,0, 1,  0,0,'h00,0, 0,0, 1,0);
    tbl[24] = mk(0, 1,'hF0,1, 0,'h00,0, 1,  1,1,'hF0,1, 1,0, 0,1);
    tbl[25] = mk(0, 0,'h00,0, 1,'hD0,0, 1,  0,0,'h00,0, 0,0, 0,0);
    tbl[26] = mk(0, 0,'h00,0, 1,'hD0,0, 1,  1,1,'hD0,0, 0,1, 1,1);
    tbl[27] = mk(0, 0,'h00,0, 1,'hD1,0, 1,  1,1,'hD1,0, 0,1, 1,1);
    tbl[28] = mk(0, 0,'h00,0, 0,'h00,0, 1,  0,0,'h00,0, 0,1, 1,1);
    tbl[29] = mk(1, 1,'h77,1, 1,'hD2,0, 1,  0,0,'h00,0, 0,0, 0,0);
    tbl[30] = mk(0, 1,'h77,1, 1,'hD2,0, 1,  0,0,'h00,0, 0,0, 0,0);
    tbl[31] = mk(0, 1,'h77,1, 1,'hD2,0, 1,  1,1,'h77,1, 1,0, 0,1);
    tbl[32] = mk(0, 0,'h00,0, 1,'hD2,1, 1,  1,1,'hD2,1, 0,1, 1,1);
    tbl[33] = mk(0, 0,'h00,0, 0,'h00,0, 1,  0,0,'h00,0, 0,0, 1,0);

    rst = 1'b1;
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_sel", c, 32'(sel), 32'd0);
      chk("rst_busy", c, 32'(busy), 32'd0);
      chk("rst_out_valid", c, 32'(out_valid), 32'd0);
      chk("rst_ready", c, 32'({in0_ready, in1_ready}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_busy", 0, 32'(busy), 32'd0);
    chk("idle_out_valid", 0, 32'(out_valid), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst       = tbl[i].rst;
      in0_valid = tbl[i].v0; in0_data = tbl[i].d0; in0_last = tbl[i].l0;
      in1_valid = tbl[i].v1; in1_data = tbl[i].d1; in1_last = tbl[i].l1;
      out_ready = tbl[i].rdy;
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].ev));
      chk("in0_ready", i, 32'(in0_ready), 32'(tbl[i].er0));
      chk("in1_ready", i, 32'(in1_ready), 32'(tbl[i].er1));
      chk("sel", i, 32'(sel), 32'(tbl[i].esel));
      chk("busy", i, 32'(busy), 32'(tbl[i].ebusy));
      if (tbl[i].cd) begin
        chk("out_data", i, 32'(out_data), 32'(tbl[i].ed));
        chk("out_last", i, 32'(out_last), 32'(tbl[i].el));
      end
    end

`ifdef MUX21_ARB_TIMEOUT_EN
    // 10-beat in0 burst against a waiting in1: handover after beat 4, resume at beat 5
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    in0_valid = 1'b1; in0_data = 8'd1;
    in1_valid = 1'b1; in1_data = 8'hB0;
    #1;
    chk("to_idle_busy", 0, 32'(busy), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in0_data = 8'(k);
      #1;
      chk("to_a_data", k, 32'(out_data), 32'(k));
      chk("to_a_sel", k, 32'(sel), 32'd0);
      chk("to_a_preempt", k, 32'(preempt), 32'd0);
    end
    @(negedge clk);
    in0_data = 8'd5;
    #1;
    chk("to_preempt", 5, 32'(preempt), 32'd1);
    chk("to_sel_b", 5, 32'(sel), 32'd1);
    chk("to_b_data", 0, 32'(out_data), 32'hB0);
    chk("to_a_ready", 5, 32'(in0_ready), 32'd0);
    @(negedge clk);
    in1_data = 8'hB1; in1_last = 1'b1;
    #1;
    chk("to_preempt_low", 6, 32'(preempt), 32'd0);
    chk("to_b_data", 1, 32'(out_data), 32'hB1);
    for (int k = 5; k <= 10; k++) begin
      @(negedge clk);
      in1_valid = 1'b0; in1_last = 1'b0;
      in0_data = 8'(k);
      in0_last = (k == 10);
      #1;
      chk("to_resume_data", k, 32'(out_data), 32'(k));
      chk("to_resume_sel", k, 32'(sel), 32'd0);
      chk("to_resume_preempt", k, 32'(preempt), 32'd0);
      chk("to_resume_ready", k, 32'(in0_ready), 32'd1);
    end
    @(negedge clk);
    in0_valid = 1'b0; in0_last = 1'b0;
    #1;
    chk("to_end_busy", 0, 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
